// File: rtl/match_controller_pkg.sv
// match_controller_pkg
// Shared state/result encodings, default match parameters and the round
// decision rule used by the match sequencer.
package match_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INTRO      = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_KO         = 3'd3,
    ST_MATCH_OVER = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_DRAW = 2'b11
  } result_e;

  localparam logic [8:0] MAX_HEALTH         = 9'd200;
  localparam logic [6:0] ROUND_TIME_DEF     = 7'd99;
  localparam logic [6:0] INTRO_SECS_DEF     = 7'd3;
  localparam logic [6:0] KO_SECS_DEF        = 7'd2;
  localparam logic [1:0] WINS_TO_MATCH_DEF  = 2'd2;
  localparam logic [2:0] MAX_ROUNDS_DEF     = 3'd5;

  // Round outcome from the two healths. A knockout always outranks the
  // timeout comparison; RES_NONE means the round is still live.
  function automatic result_e decide_round(input logic [8:0] h1,
                                           input logic [8:0] h2,
                                           input logic       time_up);
    if (h1 == 9'd0 && h2 == 9'd0) return RES_DRAW;
    if (h2 == 9'd0)               return RES_P1;
    if (h1 == 9'd0)               return RES_P2;
    if (!time_up)                 return RES_NONE;
    if (h1 > h2)                  return RES_P1;
    if (h2 > h1)                  return RES_P2;
    return RES_DRAW;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// match_controller_if
// Bundles the match controller's inputs (start, sec_tick, healths) and its
// HUD-facing outputs. slave = controller side, master = driver/observer side.
interface match_controller_if;
  logic       start;
  logic       sec_tick;
  logic [8:0] health_1;
  logic [8:0] health_2;
  logic [2:0] state;
  logic       fight_en;
  logic       health_reset;
  logic [6:0] timer;
  logic [2:0] round_num;
  logic [1:0] wins_1;
  logic [1:0] wins_2;
  logic [1:0] round_result;
  logic [1:0] match_winner;

  modport slave (
    input  start, sec_tick, health_1, health_2,
    output state, fight_en, health_reset, timer, round_num,
           wins_1, wins_2, round_result, match_winner
  );

  modport master (
    output start, sec_tick, health_1, health_2,
    input  state, fight_en, health_reset, timer, round_num,
           wins_1, wins_2, round_result, match_winner
  );
endinterface

// File: rtl/match_controller_phase_timer.sv
// phase_timer
// Loadable 7-bit seconds down-counter shared by the INTRO, FIGHT and KO
// phases. load wins over tick; the count holds at zero instead of wrapping.
// Ports: clk, reset (async, active-high), load, load_value, tick -> count, zero.
module phase_timer #(
  parameter logic [6:0] RESET_VALUE = 7'd99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] load_value,
  input  logic       tick,
  output logic [6:0] count,
  output logic       zero
);

  logic [6:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (tick && count_q != 7'd0) begin
      count_d = count_q - 7'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= RESET_VALUE;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign zero  = (count_q == 7'd0);

endmodule

// File: rtl/match_controller.sv
// match_controller
// Best-of-N match sequencer: gates hits via fight_en, pulses health_reset
// at the start of every round, runs the phase timer and decides round and
// match winners.
// Ports: clk, reset (async, active-high), bus (match_controller_if.slave).
//
// state      | meaning
// IDLE       | waiting for start
// INTRO      | pre-round countdown
// FIGHT      | round live, hits count
// KO         | holding the round result
// MATCH_OVER | holding the match result until start
module match_controller
  import match_controller_pkg::*;
#(
  parameter logic [6:0] ROUND_TIME    = ROUND_TIME_DEF,
  parameter logic [6:0] INTRO_SECS    = INTRO_SECS_DEF,
  parameter logic [6:0] KO_SECS       = KO_SECS_DEF,
  parameter logic [1:0] WINS_TO_MATCH = WINS_TO_MATCH_DEF,
  parameter logic [2:0] MAX_ROUNDS    = MAX_ROUNDS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  match_controller_if.slave  bus
);

  state_e     state_q, state_d;
  result_e    result_q, result_d;
  result_e    winner_q, winner_d;
  result_e    fight_res;
  logic [8:0] health_1_q, health_2_q;
  logic [2:0] round_q, round_d;
  logic [1:0] wins_1_q, wins_1_d;
  logic [1:0] wins_2_q, wins_2_d;
  logic       health_reset_q, health_reset_d;

  logic       tmr_load;
  logic [6:0] tmr_load_value;
  logic       tmr_tick;
  logic [6:0] tmr_count;
  logic       tmr_zero;

  // Seconds only elapse in the timed phases.
  assign tmr_tick = bus.sec_tick &&
                    (state_q == ST_INTRO || state_q == ST_FIGHT || state_q == ST_KO);

  phase_timer #(.RESET_VALUE(ROUND_TIME)) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .tick       (tmr_tick),
    .count      (tmr_count),
    .zero       (tmr_zero)
  );

  // Healths are registered before the decision so a KO acts one edge after
  // it is sampled, lining up with the timeout path (timer is registered too).
  assign fight_res = decide_round(health_1_q, health_2_q, tmr_zero);

  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    winner_d       = winner_q;
    round_d        = round_q;
    wins_1_d       = wins_1_q;
    wins_2_d       = wins_2_q;
    health_reset_d = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_value = INTRO_SECS;

    unique case (state_q)
      ST_IDLE, ST_MATCH_OVER: begin
        if (bus.start) begin
          state_d        = ST_INTRO;
          result_d       = RES_NONE;
          winner_d       = RES_NONE;
          round_d        = 3'd1;
          wins_1_d       = 2'd0;
          wins_2_d       = 2'd0;
          health_reset_d = 1'b1;
          tmr_load       = 1'b1;
          tmr_load_value = INTRO_SECS;
        end
      end
      ST_INTRO: begin
        if (tmr_zero) begin
          state_d        = ST_FIGHT;
          tmr_load       = 1'b1;
          tmr_load_value = ROUND_TIME;
        end
      end
      ST_FIGHT: begin
        if (fight_res != RES_NONE) begin
          state_d        = ST_KO;
          result_d       = fight_res;
          tmr_load       = 1'b1;
          tmr_load_value = KO_SECS;
          if (fight_res == RES_P1 && wins_1_q != WINS_TO_MATCH) wins_1_d = wins_1_q + 2'd1;
          if (fight_res == RES_P2 && wins_2_q != WINS_TO_MATCH) wins_2_d = wins_2_q + 2'd1;
        end
      end
      ST_KO: begin
        if (tmr_zero) begin
          if (wins_1_q == WINS_TO_MATCH) begin
            state_d  = ST_MATCH_OVER;
            winner_d = RES_P1;
          end else if (wins_2_q == WINS_TO_MATCH) begin
            state_d  = ST_MATCH_OVER;
            winner_d = RES_P2;
          end else if (round_q == MAX_ROUNDS) begin
            state_d  = ST_MATCH_OVER;
            winner_d = RES_DRAW;
          end else begin
            state_d        = ST_INTRO;
            round_d        = round_q + 3'd1;
            result_d       = RES_NONE;
            health_reset_d = 1'b1;
            tmr_load       = 1'b1;
            tmr_load_value = INTRO_SECS;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      result_q       <= RES_NONE;
      winner_q       <= RES_NONE;
      round_q        <= 3'd0;
      wins_1_q       <= 2'd0;
      wins_2_q       <= 2'd0;
      health_reset_q <= 1'b0;
      health_1_q     <= MAX_HEALTH;
      health_2_q     <= MAX_HEALTH;
    end else begin
      state_q        <= state_d;
      result_q       <= result_d;
      winner_q       <= winner_d;
      round_q        <= round_d;
      wins_1_q       <= wins_1_d;
      wins_2_q       <= wins_2_d;
      health_reset_q <= health_reset_d;
      health_1_q     <= bus.health_1;
      health_2_q     <= bus.health_2;
    end
  end

  assign bus.state        = state_q;
  assign bus.fight_en     = (state_q == ST_FIGHT);
  assign bus.health_reset = health_reset_q;
  assign bus.timer        = tmr_count;
  assign bus.round_num    = round_q;
  assign bus.wins_1       = wins_1_q;
  assign bus.wins_2       = wins_2_q;
  assign bus.round_result = result_q;
  assign bus.match_winner = winner_q;

endmodule

// File: tb/tb_match_controller.sv
module tb_match_controller;

  localparam int T_ROUND = 99;
  localparam int T_INTRO = 3;
  localparam int T_KO    = 2;
  localparam int NEED    = 2;
  localparam int LIMIT   = 5;

  localparam int P_IDLE = 0, P_INTRO = 1, P_FIGHT = 2, P_KO = 3, P_OVER = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   clk_run = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  match_controller_if bus();

  match_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model (match-level bookkeeping) -------------
  int m_phase, m_secs, m_rnd, m_w1, m_w2, m_res, m_win, m_hr;
  int m_seen1, m_seen2;

  task automatic model_reset();
    m_phase = P_IDLE; m_secs = T_ROUND; m_rnd = 0;
    m_w1 = 0; m_w2 = 0; m_res = 0; m_win = 0; m_hr = 0;
    m_seen1 = 200; m_seen2 = 200;
  endtask

  task automatic model_step(input bit st, input bit tk, input int a, input int b);
    int pulse;
    int outcome;
    pulse = 0;
    outcome = 0;
    case (m_phase)
      P_IDLE, P_OVER: begin
        if (st) begin
          m_phase = P_INTRO; m_w1 = 0; m_w2 = 0; m_res = 0; m_win = 0;
          m_rnd = 1; pulse = 1; m_secs = T_INTRO;
        end
      end
      P_INTRO: begin
        if (m_secs == 0) begin m_phase = P_FIGHT; m_secs = T_ROUND; end
        else if (tk) m_secs = m_secs - 1;
      end
      P_FIGHT: begin
        if (m_seen1 == 0 || m_seen2 == 0)
          outcome = (m_seen2 == 0 ? 1 : 0) + (m_seen1 == 0 ? 2 : 0);
        else if (m_secs == 0)
          outcome = (m_seen1 > m_seen2) ? 1 : (m_seen2 > m_seen1) ? 2 : 3;
        if (outcome != 0) begin
          m_phase = P_KO; m_res = outcome; m_secs = T_KO;
          if (outcome == 1 && m_w1 < NEED) m_w1 = m_w1 + 1;
          if (outcome == 2 && m_w2 < NEED) m_w2 = m_w2 + 1;
        end else if (tk && m_secs > 0) m_secs = m_secs - 1;
      end
      P_KO: begin
        if (m_secs == 0) begin
          if (m_w1 == NEED)       begin m_phase = P_OVER; m_win = 1; end
          else if (m_w2 == NEED)  begin m_phase = P_OVER; m_win = 2; end
          else if (m_rnd == LIMIT) begin m_phase = P_OVER; m_win = 3; end
          else begin
            m_phase = P_INTRO; m_rnd = m_rnd + 1; pulse = 1;
            m_res = 0; m_secs = T_INTRO;
          end
        end else if (tk) m_secs = m_secs - 1;
      end
      default: m_phase = P_IDLE;
    endcase
    m_hr = pulse;
    m_seen1 = a;
    m_seen2 = b;
  endtask

  function automatic logic [22:0] model_vec();
    return {3'(m_phase), (m_phase == P_FIGHT), 1'(m_hr), 7'(m_secs), 3'(m_rnd),
            2'(m_w1), 2'(m_w2), 2'(m_res), 2'(m_win)};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {bus.state, bus.fight_en, bus.health_reset, bus.timer, bus.round_num,
            bus.wins_1, bus.wins_2, bus.round_result, bus.match_winner};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic cycle();
    bit st, tk;
    int a, b;
    logic [22:0] got, want;
    st = bus.start; tk = bus.sec_tick; a = bus.health_1; b = bus.health_2;
    @(posedge clk);
    #1;
    model_step(st, tk, a, b);
    got = dut_vec();
    want = model_vec();
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL lockstep @%0t: got %h want %h", $time, got, want);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      bus.sec_tick = 1'b1;
      cycle();
      bus.sec_tick = 1'b0;
      repeat (9) cycle();
    end
  endtask

  // ---------------- vector table ------------------------------------------
  typedef struct {
    bit start;
    int h1, h2, ticks, cycles;
    int st, tmr, rnd, w1, w2, res, win, fe, hr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit s, int h1, int h2, int tk, int cy, int st, int tmr,
                              int rnd, int w1, int w2, int res, int win, int fe, int hr);
    vec_t v;
    v.start = s; v.h1 = h1; v.h2 = h2; v.ticks = tk; v.cycles = cy;
    v.st = st; v.tmr = tmr; v.rnd = rnd; v.w1 = w1; v.w2 = w2;
    v.res = res; v.win = win; v.fe = fe; v.hr = hr;
    return v;
  endfunction

  initial begin
    //             st  h1   h2  tk  cy  state    tmr rnd w1 w2 res win fe hr
    tbl.push_back(mk(0, 200, 200, 0, 2, P_IDLE,  99, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 200, 200, 0, 1, P_INTRO,  3, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 200, 200, 0, 1, P_INTRO,  3, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 200, 200, 3, 0, P_FIGHT, 99, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 120,   0, 0, 1, P_FIGHT, 99, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 120,   0, 0, 1, P_KO,     2, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 200, 200, 2, 0, P_INTRO,  3, 2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 200, 200, 3, 0, P_FIGHT, 99, 2, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 120,   0, 0, 2, P_KO,     2, 2, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 200, 200, 1, 0, P_KO,     1, 2, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 200, 200, 1, 2, P_OVER,   0, 2, 2, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 200, 200, 2, 0, P_OVER,   0, 2, 2, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 200, 200, 0, 1, P_INTRO,  3, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 200, 200, 3, 0, P_FIGHT, 99, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0,  80,  80, 99, 0, P_KO,    2, 1, 0, 0, 3, 0, 0, 0));
    for (int r = 2; r <= LIMIT; r++) begin
      tbl.push_back(mk(0, 80, 80, 2, 0, P_INTRO,   3, r, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 80, 80, 3, 0, P_FIGHT,  99, r, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 80, 80, 99, 0, P_KO,     2, r, 0, 0, 3, 0, 0, 0));
    end
    tbl.push_back(mk(0, 80, 80, 2, 0, P_OVER, 0, LIMIT, 0, 0, 3, 3, 0, 0));
  end

  // ---------------- test sequence -----------------------------------------
  initial begin
    bus.start = 1'b0; bus.sec_tick = 1'b0;
    bus.health_1 = 9'd200; bus.health_2 = 9'd200;
    model_reset();
    #23;
    reset = 1'b0;

    foreach (tbl[i]) begin
      bus.start = tbl[i].start;
      bus.health_1 = 9'(tbl[i].h1);
      bus.health_2 = 9'(tbl[i].h2);
      tick_n(tbl[i].ticks);
      repeat (tbl[i].cycles) cycle();
      check($sformatf("v%0d_state", i), bus.state, tbl[i].st);
      check($sformatf("v%0d_timer", i), bus.timer, tbl[i].tmr);
      check($sformatf("v%0d_round", i), bus.round_num, tbl[i].rnd);
      check($sformatf("v%0d_wins1", i), bus.wins_1, tbl[i].w1);
      check($sformatf("v%0d_wins2", i), bus.wins_2, tbl[i].w2);
      check($sformatf("v%0d_result", i), bus.round_result, tbl[i].res);
      check($sformatf("v%0d_winner", i), bus.match_winner, tbl[i].win);
      check($sformatf("v%0d_fight_en", i), bus.fight_en, tbl[i].fe);
      check($sformatf("v%0d_hreset", i), bus.health_reset, tbl[i].hr);
    end
    bus.start = 1'b0;

    // KO and timeout land on the same edge: KO rule wins, both at zero -> draw.
    bus.health_1 = 9'd200; bus.health_2 = 9'd200;
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    tick_n(3);
    tick_n(98);
    check("same_pre_timer", bus.timer, 1);
    bus.health_1 = 9'd0; bus.health_2 = 9'd0; bus.sec_tick = 1'b1;
    cycle();
    bus.sec_tick = 1'b0;
    check("same_edge_state", bus.state, P_FIGHT);
    check("same_edge_timer", bus.timer, 0);
    cycle();
    check("same_ko_state", bus.state, P_KO);
    check("same_ko_result", bus.round_result, 3);
    check("same_ko_wins1", bus.wins_1, 0);
    check("same_ko_wins2", bus.wins_2, 0);

    // Build wins_1=1 and sit in FIGHT, then reset with the clock stopped.
    bus.health_1 = 9'd200; bus.health_2 = 9'd200;
    tick_n(2);
    tick_n(3);
    bus.health_2 = 9'd0;
    cycle(); cycle();
    bus.health_2 = 9'd200;
    tick_n(2);
    tick_n(3);
    check("pre_reset_state", bus.state, P_FIGHT);
    check("pre_reset_wins1", bus.wins_1, 1);
    clk_run = 1'b0;
    #20;
    reset = 1'b1;
    #2;
    check("areset_state", bus.state, P_IDLE);
    check("areset_fight_en", bus.fight_en, 0);
    check("areset_hreset", bus.health_reset, 0);
    check("areset_timer", bus.timer, T_ROUND);
    check("areset_round", bus.round_num, 0);
    check("areset_wins1", bus.wins_1, 0);
    check("areset_wins2", bus.wins_2, 0);
    check("areset_result", bus.round_result, 0);
    check("areset_winner", bus.match_winner, 0);
    #20;
    reset = 1'b0;
    model_reset();
    clk_run = 1'b1;
    repeat (3) cycle();

    // Randomised play; the bench acts as the health datapath for restores.
    for (int n = 0; n < 4000; n++) begin
      int pick;
      bus.start = ($urandom_range(0, 59) == 0);
      bus.sec_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        pick = $urandom_range(0, 9);
        if (pick == 0)      bus.health_1 = 9'd0;
        else if (pick == 1) bus.health_2 = 9'd0;
        else if (pick == 2) begin bus.health_1 = 9'd0; bus.health_2 = 9'd0; end
        else begin
          bus.health_1 = 9'($urandom_range(1, 200));
          bus.health_2 = 9'($urandom_range(1, 200));
        end
      end
      cycle();
      if (bus.health_reset) begin
        bus.health_1 = 9'd200; bus.health_2 = 9'd200;
      end
    end
    bus.start = 1'b0; bus.sec_tick = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/match_controller.md
# match_controller

Sequences a best-of-N fight match around the health management datapath. Gates when hits count, pulses the health restore between rounds, runs the round countdown timer, and decides round and match winners from the two 9-bit health values. Sits between the input/attack logic and the health datapath; its outputs feed the HUD and the win/lose screens.

## Interface
- ROUND_TIME, 99: round length in seconds.
- INTRO_SECS, 3: pre-round countdown length in seconds.
- KO_SECS, 2: post-round hold length in seconds.
- WINS_TO_MATCH, 2: round wins needed to take the match.
- MAX_ROUNDS, 5: round limit; reaching it with no match winner ends the match as a draw.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  level; starts a match from IDLE or MATCH_OVER.
- sec_tick  in  1  one-cycle enable, once per second.
- health_1  in  9  player 1 health, 0..200.
- health_2  in  9  player 2 health, 0..200.
- state  out  3  current FSM state.
- fight_en  out  1  high only in FIGHT; the health datapath ignores hits when it is low.
- health_reset  out  1  one-cycle pulse that restores both healths to 200.
- timer  out  7  seconds remaining in the current phase.
- round_num  out  3  1-based round number; 0 in IDLE.
- wins_1  out  2  rounds won by player 1.
- wins_2  out  2  rounds won by player 2.
- round_result  out  2  00 none, 01 P1, 10 P2, 11 draw.
- match_winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

## Operation
States:
- IDLE: waits for start.
- INTRO: counts down INTRO_SECS.
- FIGHT: counts down ROUND_TIME.
- KO: holds the round result for KO_SECS.
- MATCH_OVER: holds the match result until start.

Transitions:
- IDLE or MATCH_OVER with start=1 → INTRO. Clears wins_1, wins_2, round_result and match_winner; sets round_num=1; pulses health_reset; loads timer=INTRO_SECS.
- INTRO: timer decrements on each sec_tick. When timer is 0 → FIGHT, loading timer=ROUND_TIME.
- FIGHT: fight_en=1. Every cycle, the block evaluates KO and timeout.
  - KO (either health = 0):
    - both 0 → draw
    - health_2 = 0 → P1
    - health_1 = 0 → P2
  - Timeout (timer = 0 with no KO):
    - health_1 > health_2 → P1
    - health_2 > health_1 → P2
    - equal → draw
  - On either event: go to KO, latch round_result, increment the winner's wins (a draw increments neither), load timer=KO_SECS.
  - KO has priority over timeout in the same cycle.
- KO: timer decrements on each sec_tick. When timer is 0, the first matching rule applies:
  1. wins_1 = WINS_TO_MATCH → MATCH_OVER with match_winner=01.
  2. wins_2 = WINS_TO_MATCH → MATCH_OVER with match_winner=10.
  3. round_num = MAX_ROUNDS → MATCH_OVER with match_winner=11.
  4. Otherwise → INTRO: round_num+1, health_reset pulse, round_result cleared, timer=INTRO_SECS.

Other rules:
- start is ignored in INTRO, FIGHT and KO.
- wins saturate at WINS_TO_MATCH.
- timer saturates at 0 and never wraps.
- sec_tick in IDLE and MATCH_OVER has no effect.

## Timing
- Reset values:
  - state=IDLE, fight_en=0, health_reset=0, timer=ROUND_TIME.
  - round_num=0, wins_1=wins_2=0.
  - round_result=00, match_winner=00.
- All outputs are registered. fight_en and health_reset are decoded from registered state and registered pulse flags, with no combinational path from inputs.
- health_reset asserts on the first cycle in INTRO and lasts exactly one cycle.
- Health at 0 seen at edge N:
  - state=KO, round_result valid, wins updated, fight_en=0 after edge N+1.
  - Hits arriving during that cycle may still land; the datapath clamps health at 0.
- Timeout: the sec_tick that takes timer 1→0 is at edge N; KO is entered at edge N+1.
- Reset mid-match returns everything to reset values immediately, asynchronously. Round progress is not retained.
- start held high through MATCH_OVER immediately restarts the match; this is intended.

## Structure
- Shared package holds:
  - state encodings: IDLE=0, INTRO=1, FIGHT=2, KO=3, MATCH_OVER=4
  - result codes: NONE, P1, P2, DRAW
  - MAX_HEALTH=200
- One sub-module, phase_timer: loadable 7-bit down-counter.
  - Inputs: load, load_value, tick.
  - Outputs: count and zero.
  - Used for all three timed phases.
- The match_controller top holds the FSM, the winner-decision logic and the win/round counters.

## Test plan
- Reset, then start with sec_tick every 10 cycles:
  - health_reset pulses for one cycle.
  - INTRO lasts 3 ticks, then FIGHT with timer=99 and fight_en=1.
- In FIGHT, drive health_2=0, health_1=120:
  - Next cycle: KO, round_result=01, wins_1=1, fight_en=0.
  - After 2 ticks: INTRO, round_num=2.
- P1 wins two rounds:
  - MATCH_OVER with match_winner=01.
  - start ignored while in KO; start in MATCH_OVER clears wins and sets round_num=1.
- Timeout with health_1=80, health_2=80:
  - round_result=11, neither wins count changes.
  - Repeat 5 draws: MATCH_OVER with match_winner=11.
- Same cycle: health_1=0, health_2=0, and timer reaching 0:
  - KO with round_result=11, no wins change.
- Assert reset mid-FIGHT with wins_1=1:
  - All outputs return to reset values immediately, including while clk is stopped.
